// File: rtl/resampler_pkg.sv
// resampler_pkg: shared types and constants for the resampler phase sequencer.
//   state_e    - sequencer states
//   PPM_SCALE  - ppm to UQ2.32 step scale (about 2^32 / 1e6)
//   PEND_W     - width of the per-output pending pop count (0..2)
//   URUN_W     - width of the saturating underrun counter
//   clamp_ppm  - symmetric clamp of a signed ppm request
package resampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CONSUME = 2'd3
  } state_e;

  localparam int PPM_SCALE = 4295;
  localparam int PEND_W    = 2;
  localparam int URUN_W    = 16;

  function automatic logic signed [31:0] clamp_ppm(input logic signed [31:0] value,
                                                   input int limit);
    logic signed [31:0] res;
    if (value > limit) begin
      res = limit;
    end else if (value < -limit) begin
      res = -limit;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/resampler_phase_ctrl_if.sv
// resampler_phase_ctrl_if: sample/output handshake between the phase
// sequencer, the input FIFO read side and the resampler core.
//   in_avail - FIFO not empty            (slave -> master)
//   in_pop   - FIFO read / sample accept (master -> slave)
//   out_req  - downstream output request (slave -> master)
//   out_fire - output produced           (master -> slave)
//   mu       - phase for this output     (master -> slave)
interface resampler_phase_ctrl_if #(
  parameter int MU_BITS = 15
) ();
  logic               in_avail;
  logic               in_pop;
  logic               out_req;
  logic               out_fire;
  logic [MU_BITS-1:0] mu;

  modport master (input in_avail, input out_req, output in_pop, output out_fire, output mu);
  modport slave  (output in_avail, output out_req, input in_pop, input out_fire, input mu);
endinterface

// File: rtl/resampler_phase_ctrl_ppm_step_calc.sv
// ppm_step_calc: clamps a ppm request, forms step = 2^PHASE_BITS + ppm*PPM_SCALE
// and holds it in a shadow register until the sequencer takes it.
//   clk, rst    - clock, async active-high reset
//   ppm_value   - signed ppm request
//   ppm_load    - pulse: capture ppm_value (last load wins)
//   take        - sequencer copied the shadow into its active step
//   step_shadow - pending step (signed UQ2.PHASE_BITS)
//   shadow_pend - step_shadow holds a value not yet taken
module ppm_step_calc
  import resampler_pkg::*;
#(
  parameter int PHASE_BITS = 32,
  parameter int PPM_MAX    = 1000,
  localparam int STEP_W    = PHASE_BITS + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [31:0]       ppm_value,
  input  logic                     ppm_load,
  input  logic                     take,
  output logic signed [STEP_W-1:0] step_shadow,
  output logic                     shadow_pend
);

  localparam logic signed [STEP_W-1:0] STEP_ONE = $signed({2'b01, {PHASE_BITS{1'b0}}});

  logic signed [31:0]       ppm_c_s;
  logic signed [STEP_W-1:0] step_s;
  logic signed [STEP_W-1:0] step_shadow_r;
  logic                     shadow_pend_r;

  // Clamp and scale the request; |delta| stays far below 2^PHASE_BITS.
  always_comb begin
    ppm_c_s = clamp_ppm(ppm_value, PPM_MAX);
    step_s  = STEP_ONE + (STEP_W'(ppm_c_s) * STEP_W'(PPM_SCALE));
  end

  // Shadow register; a new load overrides a simultaneous take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_shadow_r <= STEP_ONE;
      shadow_pend_r <= 1'b0;
    end else if (ppm_load) begin
      step_shadow_r <= step_s;
      shadow_pend_r <= 1'b1;
    end else if (take) begin
      shadow_pend_r <= 1'b0;
    end else begin
      shadow_pend_r <= shadow_pend_r;
    end
  end

  assign step_shadow = step_shadow_r;
  assign shadow_pend = shadow_pend_r;

endmodule

// File: rtl/resampler_phase_ctrl.sv
// resampler_phase_ctrl: primes the core delay line with TAP_COUNT samples, then
// for each output request advances a UQ2.PHASE_BITS phase accumulator, pops the
// 0..2 samples the carry asks for and presents the fractional phase as mu.
//   clk, rst     - clock, async active-high reset
//   enable       - level; low returns to IDLE and blocks pops/fires
//   ppm_value    - signed ppm request, captured on ppm_load
//   ppm_load     - pulse
//   clear        - pulse; zeroes underrun and underrun_cnt (wins over starvation)
//   bus          - FIFO/core handshake (in_avail, in_pop, out_req, out_fire, mu)
//   primed       - delay line full (RUN or CONSUME)
//   underrun     - sticky: CONSUME cycle with FIFO empty seen
//   underrun_cnt - saturating count of starved cycles
module resampler_phase_ctrl
  import resampler_pkg::*;
#(
  parameter int PHASE_BITS = 32,
  parameter int MU_BITS    = 15,
  parameter int TAP_COUNT  = 9,
  parameter int PPM_MAX    = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic signed [31:0]     ppm_value,
  input  logic                   ppm_load,
  input  logic                   clear,
  resampler_phase_ctrl_if.master bus,
  output logic                   primed,
  output logic                   underrun,
  output logic [URUN_W-1:0]      underrun_cnt
);

  localparam int STEP_W = PHASE_BITS + 2;
  localparam int CNT_W  = $clog2(TAP_COUNT + 1);
  localparam logic signed [STEP_W-1:0] STEP_ONE = $signed({2'b01, {PHASE_BITS{1'b0}}});

  state_e                   state_r, state_s;
  logic [PHASE_BITS-1:0]    frac_r;
  logic signed [STEP_W-1:0] step_active_r;
  logic signed [STEP_W-1:0] step_shadow_s;
  logic                     shadow_pend_s;
  logic                     take_s;
  logic [PEND_W-1:0]        pend_r;
  logic [CNT_W-1:0]         prime_cnt_r;
  logic [STEP_W-1:0]        sum_s;
  logic                     fire_s, pop_s, starve_s;
  logic                     underrun_r;
  logic [URUN_W-1:0]        underrun_cnt_r;

  ppm_step_calc #(.PHASE_BITS(PHASE_BITS), .PPM_MAX(PPM_MAX)) u_step (
    .clk        (clk),
    .rst        (rst),
    .ppm_value  (ppm_value),
    .ppm_load   (ppm_load),
    .take       (take_s),
    .step_shadow(step_shadow_s),
    .shadow_pend(shadow_pend_s)
  );

  // Step is always positive, so the sum is plain unsigned; the top two bits
  // are the number of input samples this output advances over.
  assign sum_s = STEP_W'(frac_r) + $unsigned(step_active_r);

  // A pending shadow is taken at once in IDLE, otherwise on a fire (which
  // itself still uses the old step_active_r).
  assign take_s = shadow_pend_s && ((state_r == ST_IDLE) || fire_s);

  // Next-state and handshake strobes.
  always_comb begin
    state_s  = state_r;
    fire_s   = 1'b0;
    pop_s    = 1'b0;
    starve_s = 1'b0;
    if (!enable) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_PRIME;
        end
        ST_PRIME: begin
          pop_s = bus.in_avail;
          if (pop_s && (prime_cnt_r == CNT_W'(TAP_COUNT - 1))) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PRIME;
          end
        end
        ST_RUN: begin
          fire_s = bus.out_req;
          if (fire_s && (sum_s[PHASE_BITS+1:PHASE_BITS] != 2'b00)) begin
            state_s = ST_CONSUME;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_CONSUME: begin
          pop_s    = bus.in_avail;
          starve_s = !bus.in_avail;
          if (pop_s && (pend_r == PEND_W'(1))) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_CONSUME;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Phase accumulator, pending pops, prime counter and active step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_r        <= {PHASE_BITS{1'b0}};
      pend_r        <= {PEND_W{1'b0}};
      prime_cnt_r   <= {CNT_W{1'b0}};
      step_active_r <= STEP_ONE;
    end else begin
      if (take_s) begin
        step_active_r <= step_shadow_s;
      end
      case (state_r)
        ST_IDLE: begin
          frac_r      <= {PHASE_BITS{1'b0}};
          pend_r      <= {PEND_W{1'b0}};
          prime_cnt_r <= {CNT_W{1'b0}};
        end
        ST_PRIME: begin
          if (pop_s) begin
            prime_cnt_r <= prime_cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (fire_s) begin
            frac_r <= sum_s[PHASE_BITS-1:0];
            pend_r <= sum_s[PHASE_BITS+1:PHASE_BITS];
          end
        end
        ST_CONSUME: begin
          if (pop_s) begin
            pend_r <= pend_r - PEND_W'(1);
          end
        end
        default: begin
          frac_r <= {PHASE_BITS{1'b0}};
        end
      endcase
    end
  end

  // Sticky starvation flag and saturating counter; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_r     <= 1'b0;
      underrun_cnt_r <= {URUN_W{1'b0}};
    end else if (clear) begin
      underrun_r     <= 1'b0;
      underrun_cnt_r <= {URUN_W{1'b0}};
    end else if (starve_s) begin
      underrun_r <= 1'b1;
      if (underrun_cnt_r != {URUN_W{1'b1}}) begin
        underrun_cnt_r <= underrun_cnt_r + URUN_W'(1);
      end
    end
  end

  assign bus.in_pop   = pop_s;
  assign bus.out_fire = fire_s;
  assign bus.mu       = frac_r[PHASE_BITS-1 -: MU_BITS];
  assign primed       = (state_r == ST_RUN) || (state_r == ST_CONSUME);
  assign underrun     = underrun_r;
  assign underrun_cnt = underrun_cnt_r;

endmodule
